occ_read_arbiter: RTL
=====================

# occ_read_arbiter

Arbitrates shared access to the dual-read-port Occ-table SRAM (sram_OCCA) among NUM_REQ backward-search engines plus one table-load write port. Each accepted read presents an address pair (k-row, l-row) and receives both Occ rows two cycles later. Round-robin fairness, one read per cycle, and a same-cycle read-after-write hazard stall. Sits between the search engines and the SRAM instance; owns all SRAM control pins.

## Interface
- NUM_REQ, 4, number of read requesters
- DEPTH, 18, SRAM rows; addresses ≥ DEPTH are out of range
- WIDTHS, 1920, SRAM row width
- ADDR_WIDTH, 5, SRAM address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr0 / req_addr1  in  NUM_REQ*ADDR_WIDTH  flat; slice i = requester i's two row addresses
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot; response for requester i this cycle
- rsp_err  out  1  qualifies rsp_valid; 1 = out-of-range address, data invalid
- rsp_data0 / rsp_data1  out  WIDTHS  broadcast response rows (from SRAM)
- wr_valid  in  1  table-load write
- wr_addr  in  ADDR_WIDTH; wr_data  in  WIDTHS
- sram_wEn, sram_rEn  out  1; sram_wAddr, sram_rAddr0, sram_rAddr1  out  ADDR_WIDTH; sram_wData  out  WIDTHS
- sram_rData0 / sram_rData1  in  WIDTHS  SRAM outputs (1-cycle registered read)

## Operation
- Stage A (accept, cycle T): arbiter picks one eligible requester; eligible = req_valid[i] and not hazarded. Grant is combinational from req_valid, registered pointer.
- Round-robin: priority starts at (last_grant+1) mod NUM_REQ; last_grant updates only on a transfer. Reset last_grant = NUM_REQ-1 so requester 0 wins first.
- Hazard: if wr_valid at T and wr_addr equals req_addr0[i] or req_addr1[i], requester i is ineligible at T; others still arbitrate.
- Writes always accepted (no wr_ready); registered into stage B with the read.
- Stage B (issue, T+1): registers drive sram_rEn=1, sram_rAddr0/1, and sram_wEn/wAddr/wData. Registered id and err flag travel with the read.
- Out-of-range read (either address ≥ DEPTH): accepted normally, sram_rEn stays 0 in stage B, err flag set.
- Stage C (T+2): rsp_valid[id]=1, rsp_err=err flag, rsp_data0/1 = sram_rData0/1 passthrough.
- Requester must hold req_valid/addr stable until granted; may drop req_valid before grant without effect.

## Timing
- Read latency: accept T → rsp_valid T+2. Throughput: one read and one write per cycle.
- Write accepted at T is visible to reads accepted at T+1 or later.
- Reset values: req_ready=0 during rst, rsp_valid=0, rsp_err=0, sram_rEn=0, sram_wEn=0, addresses 0, stage B/C valid bits 0, last_grant=NUM_REQ-1. rsp_data follows SRAM (not reset).
- rst mid-operation: in-flight stage B/C reads dropped, no rsp_valid in cycle after rst; pending writes in stage B dropped.
- No requester valid: sram_rEn=0, pointer unchanged.

## Structure
- Shared package occ_pkg: ADDR_WIDTH, WIDTHS, DEPTH defaults, requester-id width ($clog2(NUM_REQ)).
- One sub-module: occ_rr_arbiter (NUM_REQ-bit eligible in, one-hot grant out, pointer register, advance on transfer). Remainder is the stage B/C pipeline in the top.

## Test plan
- Single request: req 2 valid, addr0=3, addr1=7, preloaded rows → req_ready[2] at T, sram_rAddr0=3/rAddr1=7 with rEn at T+1, rsp_valid=4'b0100 with rows 3,7 at T+2.
- All four valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; back-to-back rsp_valid one per cycle.
- wr_valid addr 5 with req 0 addr0=5 and req 1 addr0=9 same cycle → req 1 granted, req 0 granted next cycle and receives new row 5 data.
- Out-of-range: req 3 addr1=20 (DEPTH=18) → accepted, sram_rEn=0 at T+1, rsp_valid[3]=1, rsp_err=1 at T+2.
- Reset mid-stream: assert rst for 1 cycle with reads in stages B and C → no rsp_valid afterward for them, next grant goes to requester 0.

Source files
------------

// File: rtl/occ_pkg.sv
// Shared constants for the Occ-table read arbiter: default geometry and requester-id sizing.
package occ_pkg;
   localparam int OCC_NUM_REQ    = 4;
   localparam int OCC_DEPTH      = 18;
   localparam int OCC_WIDTHS     = 1920;
   localparam int OCC_ADDR_WIDTH = 5;

   function automatic int idWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int OCC_ID_WIDTH = idWidth(OCC_NUM_REQ);
endpackage

// File: rtl/occ_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters, priority starting after the last grant.
module occ_rr_arbiter
   import occ_pkg::*;
#(
   parameter int NUM_REQ = OCC_NUM_REQ
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] eligible,
   output logic [NUM_REQ-1:0] grant
);
   localparam int IDW = idWidth(NUM_REQ);

   logic [IDW-1:0] lastGrant;
   logic [IDW-1:0] grantId;
   logic [IDW-1:0] idx;
   logic           found;
   int             sum;

   always_comb begin
      grant   = '0;
      grantId = lastGrant;
      found   = 1'b0;
      idx     = '0;
      sum     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = int'(lastGrant) + k;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = IDW'(sum);
         if (!found && eligible[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grantId    = idx;
         end
      end
   end

   // Eligible already implies req_valid, so any grant is a transfer.
   always_ff @(posedge clk) begin
      if (rst)        lastGrant <= IDW'(NUM_REQ - 1);
      else if (found) lastGrant <= grantId;
   end
endmodule

// File: rtl/occ_read_arbiter.sv
// Occ-table SRAM front end: arbitrates search-engine reads, forwards table-load writes,
// and returns both Occ rows two cycles after accept.
module occ_read_arbiter
   import occ_pkg::*;
#(
   parameter int NUM_REQ    = OCC_NUM_REQ,
   parameter int DEPTH      = OCC_DEPTH,
   parameter int WIDTHS     = OCC_WIDTHS,
   parameter int ADDR_WIDTH = OCC_ADDR_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr0,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr1,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic                          rsp_err,
   output logic [WIDTHS-1:0]             rsp_data0,
   output logic [WIDTHS-1:0]             rsp_data1,
   input  logic                          wr_valid,
   input  logic [ADDR_WIDTH-1:0]         wr_addr,
   input  logic [WIDTHS-1:0]             wr_data,
   output logic                          sram_wEn,
   output logic                          sram_rEn,
   output logic [ADDR_WIDTH-1:0]         sram_wAddr,
   output logic [ADDR_WIDTH-1:0]         sram_rAddr0,
   output logic [ADDR_WIDTH-1:0]         sram_rAddr1,
   output logic [WIDTHS-1:0]             sram_wData,
   input  logic [WIDTHS-1:0]             sram_rData0,
   input  logic [WIDTHS-1:0]             sram_rData1
);
   localparam int IDW = idWidth(NUM_REQ);

   logic [NUM_REQ-1:0]    eligible, grant;
   logic                  acceptVld, acceptErr;
   logic [IDW-1:0]        acceptId, bId, cId;
   logic [ADDR_WIDTH-1:0] acceptAddr0, acceptAddr1;
   logic                  bErr, cErr;
   logic [2:1]            vldPipe;   // [1] issue stage, [2] response stage

   // A write landing in the SRAM next cycle would race a read of the same row.
   for (genvar i = 0; i < NUM_REQ; i++) begin : gElig
      assign eligible[i] = req_valid[i] && !rst &&
         !(wr_valid && (wr_addr == req_addr0[i*ADDR_WIDTH +: ADDR_WIDTH] ||
                        wr_addr == req_addr1[i*ADDR_WIDTH +: ADDR_WIDTH]));
   end

   occ_rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
      .clk      (clk),
      .rst      (rst),
      .eligible (eligible),
      .grant    (grant)
   );

   assign req_ready = grant;
   assign acceptVld = |grant;

   always_comb begin
      acceptId    = '0;
      acceptAddr0 = '0;
      acceptAddr1 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            acceptId    = IDW'(i);
            acceptAddr0 = req_addr0[i*ADDR_WIDTH +: ADDR_WIDTH];
            acceptAddr1 = req_addr1[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
      acceptErr = (int'(acceptAddr0) >= DEPTH) || (int'(acceptAddr1) >= DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vldPipe     <= '0;
         sram_rEn    <= 1'b0;
         sram_wEn    <= 1'b0;
         sram_rAddr0 <= '0;
         sram_rAddr1 <= '0;
         sram_wAddr  <= '0;
         bId         <= '0;
         bErr        <= 1'b0;
         cId         <= '0;
         cErr        <= 1'b0;
      end else begin
         vldPipe  <= {vldPipe[1], acceptVld};
         sram_rEn <= acceptVld && !acceptErr;
         sram_wEn <= wr_valid;
         if (acceptVld) begin
            sram_rAddr0 <= acceptAddr0;
            sram_rAddr1 <= acceptAddr1;
            bId         <= acceptId;
            bErr        <= acceptErr;
         end
         if (wr_valid) sram_wAddr <= wr_addr;
         cId  <= bId;
         cErr <= bErr;
      end
   end

   // Write data only matters when sram_wEn is set, so it skips reset.
   always_ff @(posedge clk) begin
      if (wr_valid) sram_wData <= wr_data;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = vldPipe[2] && (cId == IDW'(i));
   end

   assign rsp_err   = vldPipe[2] && cErr;
   assign rsp_data0 = sram_rData0;
   assign rsp_data1 = sram_rData1;
endmodule
